// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM/owner types and default sizing shared by mem_port_arbiter.
// STARVE_MAX_DEF exists only when MEM_ARB_STARVE_GUARD_EN is defined.
package mem_arb_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int MEM_LAT_DEF = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_MAX_DEF = 4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter that flags the last cycle of the
// memory latency window (expire when the count reaches 1).
module mem_lat_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and load/store.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = STARVE_MAX_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e r_state;
  state_e w_next_state;
  owner_e r_owner;
  logic   w_expire;
  logic   w_fetch_pri;
  logic   w_d_win;
  logic   w_if_win;

  // Grants are gated by reset so nothing is accepted while it is asserted.
  assign w_d_win  = reset && d_req && !(if_req && w_fetch_pri);
  assign w_if_win = reset && if_req && !w_d_win;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_starve_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (if_gnt) begin
      r_starve_cnt <= '0;
    end else if (d_gnt && if_req && (r_starve_cnt != STARVE_LIM)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_fetch_pri = (r_starve_cnt == STARVE_LIM);
`else
  assign w_fetch_pri = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (if_req || d_req) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = ST_WAIT;
      ST_WAIT:   if (w_expire) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = (r_state != ST_IDLE);
    unique case (r_state)
      ST_IDLE: begin
        d_gnt  = w_d_win;
        if_gnt = w_if_win;
      end
      ST_ACCESS: mem_en = 1'b1;
      ST_WAIT: begin
        if_rvalid = w_expire && (r_owner == OWN_IF);
        d_rvalid  = w_expire && (r_owner == OWN_D);
      end
      default: ;
    endcase
  end

  // Capture the winner's command; it is held on the port until the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r_owner   <= OWN_IF;
    end else if (d_gnt) begin
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      r_owner   <= OWN_D;
    end else if (if_gnt) begin
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      r_owner   <= OWN_IF;
    end
  end

  mem_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == ST_ACCESS),
    .i_dec    (r_state == ST_WAIT),
    .o_expire (w_expire)
  );

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-timeline model predicts
// grants, memory strobes and responses; a negedge monitor compares them.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_MAX = 4;
`endif

  typedef struct {
    int          cyc;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MEM_LAT (MEM_LAT)
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    .STARVE_MAX (STARVE_MAX)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  ev_t gq[$];
  ev_t mq[$];
  ev_t rq[$];

  int next_free = 0;
  bit if_taken = 1'b0;
  bit d_taken = 1'b0;
  int m_starve = 0;

  logic [31:0] m_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory device: performs the strobed access and presents read data.
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_we) dev_mem[mem_addr] = mem_wdata;
      else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
    end
  end

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      check("reset_outputs", {57'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, 64'd0);
      check("reset_mem_regs", {mem_addr, mem_wdata}, 64'd0);
      check("reset_rdata_pass", {32'd0, rdata}, {32'd0, mem_rdata});
    end else begin
      check("busy", {63'd0, busy},
            {63'd0, (cyc < next_free) && (cyc + MEM_LAT + 1 >= next_free)});
      if (if_gnt || d_gnt || (gq.size() > 0 && gq[0].cyc == cyc)) begin
        if (gq.size() == 0) begin
          check("unexpected_gnt", {62'd0, if_gnt, d_gnt}, 64'd0);
        end else begin
          e = gq.pop_front();
          check("gnt_cycle", 64'(cyc), 64'(e.cyc));
          check("gnt_owner", {62'd0, if_gnt, d_gnt}, e.is_d ? 64'd1 : 64'd2);
        end
      end
      if (mem_en || (mq.size() > 0 && mq[0].cyc == cyc)) begin
        if (mq.size() == 0) begin
          check("unexpected_mem_en", {63'd0, mem_en}, 64'd0);
        end else begin
          e = mq.pop_front();
          check("mem_en_cycle", 64'(cyc), 64'(e.cyc));
          check("mem_we_addr", {31'd0, mem_we, mem_addr}, {31'd0, e.we, e.addr});
          if (e.we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
        end
      end
      if (if_rvalid || d_rvalid || (rq.size() > 0 && rq[0].cyc == cyc)) begin
        if (rq.size() == 0) begin
          check("unexpected_rvalid", {62'd0, if_rvalid, d_rvalid}, 64'd0);
        end else begin
          e = rq.pop_front();
          check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
          check("rvalid_owner", {62'd0, if_rvalid, d_rvalid}, e.is_d ? 64'd1 : 64'd2);
          if (!e.we) check("rdata", {32'd0, rdata}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (if_taken) begin if_req = 1'b0; if_taken = 1'b0; end
    if (d_taken) begin d_req = 1'b0; d_taken = 1'b0; end
  endtask

  // Reference model: one transaction at a time, the port frees MEM_LAT+2
  // cycles after a grant; data wins ties unless the fetch has starved.
  task automatic arb();
    ev_t e;
    bit d_wins;
    if (!reset || cyc < next_free || !(if_req || d_req)) return;
`ifdef MEM_ARB_STARVE_GUARD_EN
    d_wins = d_req && !(if_req && m_starve == STARVE_MAX);
    if (!d_wins) m_starve = 0;
    else if (if_req && m_starve < STARVE_MAX) m_starve++;
`else
    d_wins = d_req;
`endif
    e.cyc  = cyc;
    e.is_d = d_wins;
    e.we   = d_wins ? d_we : 1'b0;
    e.addr = d_wins ? d_addr : if_addr;
    e.data = d_wins ? d_wdata : 32'd0;
    gq.push_back(e);
    e.cyc = cyc + 1;
    mq.push_back(e);
    if (e.we) m_mem[e.addr] = e.data;
    else e.data = m_mem.exists(e.addr) ? m_mem[e.addr] : init_val(e.addr);
    e.cyc = cyc + 1 + MEM_LAT;
    rq.push_back(e);
    next_free = cyc + 2 + MEM_LAT;
    if (d_wins) d_taken = 1'b1;
    else if_taken = 1'b1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && (cyc < next_free || if_req || d_req); k++) begin
      next_cycle();
      arb();
    end
  endtask

  task automatic run_cycles(input int n, input bit raise_if, input bit raise_d);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      if (raise_if && !if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      end
      if (raise_d && !d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'h200 + 32'(4 * $urandom_range(0, 7));
        d_wdata = $urandom;
      end
      arb();
    end
  endtask

  initial begin
    m_mem[32'h100] = 32'hDEADBEEF;
    dev_mem[32'h100] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);

    // Release reset with a fetch pending: granted on the first high edge.
    next_cycle();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    next_free = cyc;
    arb();
    wait_idle();

    // Data write, then read it back.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
    arb();
    wait_idle();
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    arb();
    wait_idle();

    // Simultaneous requests.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    arb();
    wait_idle();

    // Data request raised during WAIT is held off until IDLE.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h108;
    arb();
    next_cycle(); arb();
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h204;
    arb();
    wait_idle();

    // Fetch held high against back-to-back data traffic.
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      if (!if_req) begin if_req = 1'b1; if_addr = 32'h10C; end
      if (!d_req) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'h208; d_wdata = $urandom;
      end
      arb();
    end
    wait_idle();

    // Reset in the middle of a read: response dropped, outputs cleared.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h140;
    arb();
    next_cycle(); arb();
    next_cycle();
    reset = 1'b0;
    rq.delete();
    next_free = 0; m_starve = 0;
    if_req = 1'b0; d_req = 1'b0; if_taken = 1'b0; d_taken = 1'b0;
    repeat (2) next_cycle();
    next_cycle();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h180;
    next_free = cyc;
    arb();
    wait_idle();

    // Randomized traffic, then drain.
    run_cycles(400, 1'b1, 1'b1);
    run_cycles(30, 1'b0, 1'b0);
    wait_idle();
    next_cycle();
    @(negedge clk);
    #1;
    check("drain_queues", 64'(gq.size() + mq.size() + rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
